// File: rtl/operand_issue_stage.sv
// operand_issue_stage
//   Register read / dispatch stage between decode and the calculation units.
//   Holds the architectural register file (x0 hardwired to zero), a per-register
//   busy scoreboard and NUM_WB writeback ports. RAW and WAW hazards are stalled.
//   Operands leave through a single valid/ready output register, one cycle
//   after acceptance.
//
//   Optional feature macro: BYPASS_EN
//     defined   : a writeback in the current cycle satisfies a pending source or
//                 destination, and its data is forwarded straight into the packet.
//     undefined : a dependent instruction issues the cycle after the writeback
//                 and reads the updated register file.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   decode-side handshake
//   in_ctrl/pc/imm      pass-through control, PC and expanded immediate
//   in_rs1_ad/rs2_ad    source addresses, with in_rs1_used/in_rs2_used
//   in_rd_ad/in_rd_wr   destination address and write flag
//   out_valid/out_ready unit-side handshake
//   out_*               registered packet (operands are 0 when not used)
//   wb_valid/ad/data    NUM_WB packed writeback ports, port i at [i*W +: W]
//   flush               kills the issued packet and clears the scoreboard
module operand_issue_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NUM_WB = 2,
  parameter int CTRL_W = 10,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [AW-1:0]          in_rs1_ad,
  input  logic [AW-1:0]          in_rs2_ad,
  input  logic                   in_rs1_used,
  input  logic                   in_rs2_used,
  input  logic [AW-1:0]          in_rd_ad,
  input  logic                   in_rd_wr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_rs1,
  output logic [XLEN-1:0]        out_rs2,
  output logic [AW-1:0]          out_rd_ad,
  output logic                   out_rd_wr,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_ad,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  input  logic                   flush
);

  logic [XLEN-1:0]   rf_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              out_valid_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [XLEN-1:0]   out_pc_q, out_imm_q, out_rs1_q, out_rs2_q;
  logic [AW-1:0]     out_rd_ad_q;
  logic              out_rd_wr_q;

  logic            rs1_hit, rs2_hit, rd_hit;
  logic [XLEN-1:0] rs1_byp, rs2_byp;
  logic            rs1_ok, rs2_ok, waw, hazard, space, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef BYPASS_EN
  // Scan ports in ascending order so the highest matching index supplies data,
  // mirroring the register-file write priority.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rd_hit  = 1'b0;
    rs1_byp = '0;
    rs2_byp = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && wb_ad[i*AW +: AW] != '0) begin
        if (wb_ad[i*AW +: AW] == in_rs1_ad) begin
          rs1_hit = 1'b1;
          rs1_byp = wb_data[i*XLEN +: XLEN];
        end
        if (wb_ad[i*AW +: AW] == in_rs2_ad) begin
          rs2_hit = 1'b1;
          rs2_byp = wb_data[i*XLEN +: XLEN];
        end
        if (wb_ad[i*AW +: AW] == in_rd_ad) rd_hit = 1'b1;
      end
    end
  end
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
  assign rd_hit  = 1'b0;
  assign rs1_byp = '0;
  assign rs2_byp = '0;
`endif

  assign rs1_ok = !in_rs1_used || (in_rs1_ad == '0) || !busy_q[in_rs1_ad] || rs1_hit;
  assign rs2_ok = !in_rs2_used || (in_rs2_ad == '0) || !busy_q[in_rs2_ad] || rs2_hit;
  // WAW: a second writer to a pending rd must wait so writebacks retire in order.
  assign waw    = in_rd_wr && (in_rd_ad != '0) && busy_q[in_rd_ad] && !rd_hit;
  assign hazard = !rs1_ok || !rs2_ok || waw;
  assign space  = !out_valid_q || out_ready;
  assign in_ready = space && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  assign rs1_val = (!in_rs1_used || in_rs1_ad == '0) ? '0 :
                   rs1_hit ? rs1_byp : rf_q[in_rs1_ad];
  assign rs2_val = (!in_rs2_used || in_rs2_ad == '0) ? '0 :
                   rs2_hit ? rs2_byp : rf_q[in_rs2_ad];

  // Scoreboard next state: clears from writebacks first, then the new claim,
  // so a simultaneous set and clear of the same register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i]) busy_d[wb_ad[i*AW +: AW]] = 1'b0;
      end
      if (accept && in_rd_wr && in_rd_ad != '0) busy_d[in_rd_ad] = 1'b1;
    end
  end

  // Register file: later ports overwrite earlier ones on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && wb_ad[i*AW +: AW] != '0)
          rf_q[wb_ad[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Output register: loads on accept, otherwise holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_pc_q    <= '0;
      out_imm_q   <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_ad_q <= '0;
      out_rd_wr_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_ctrl_q  <= in_ctrl;
      out_pc_q    <= in_pc;
      out_imm_q   <= in_imm;
      out_rs1_q   <= rs1_val;
      out_rs2_q   <= rs2_val;
      out_rd_ad_q <= in_rd_ad;
      out_rd_wr_q <= in_rd_wr;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_pc    = out_pc_q;
  assign out_imm   = out_imm_q;
  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;
  assign out_rd_ad = out_rd_ad_q;
  assign out_rd_wr = out_rd_wr_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage (default parameters). Expectations
// that depend on the writeback bypass are selected with BYPASS_EN.
module tb_operand_issue_stage;
  localparam int XLEN = 32, NREG = 32, NUM_WB = 2, CTRL_W = 10, AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [XLEN-1:0]   in_pc, in_imm;
  logic [AW-1:0]     in_rs1_ad, in_rs2_ad, in_rd_ad;
  logic              in_rs1_used, in_rs2_used, in_rd_wr;
  logic              out_valid, out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_pc, out_imm, out_rs1, out_rs2;
  logic [AW-1:0]     out_rd_ad;
  logic              out_rd_wr;
  logic [NUM_WB-1:0]      wb_valid;
  logic [NUM_WB*AW-1:0]   wb_ad;
  logic [NUM_WB*XLEN-1:0] wb_data;
  logic              flush;

  int n_cmp = 0;
  int n_err = 0;

  operand_issue_stage #(.XLEN(XLEN), .NREG(NREG), .NUM_WB(NUM_WB), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_pc(in_pc),
    .in_imm(in_imm), .in_rs1_ad(in_rs1_ad), .in_rs2_ad(in_rs2_ad),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd_ad(in_rd_ad), .in_rd_wr(in_rd_wr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd_ad(out_rd_ad), .out_rd_wr(out_rd_wr),
    .wb_valid(wb_valid), .wb_ad(wb_ad), .wb_data(wb_data), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [CTRL_W-1:0] c, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] imm, input logic [AW-1:0] r1, input logic u1,
                        input logic [AW-1:0] r2, input logic u2,
                        input logic [AW-1:0] rd, input logic wr);
    in_valid = v; in_ctrl = c; in_pc = pc; in_imm = imm;
    in_rs1_ad = r1; in_rs1_used = u1; in_rs2_ad = r2; in_rs2_used = u2;
    in_rd_ad = rd; in_rd_wr = wr;
    #1;
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                        input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
    wb_valid = v; wb_ad = {a1, a0}; wb_data = {d1, d0};
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    set_wb(2'b00, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_out_rs1", {32'd0, out_rs1}, 64'd0);
    chk("rst_out_rd_ad", {59'd0, out_rd_ad}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // addi-like: rs1=x0, rd=x5, imm=7
    set_in(1, 10'h015, 32'h100, 32'd7, 5'd0, 1, 5'd0, 0, 5'd5, 1);
    chk("addi_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_rs1", {32'd0, out_rs1}, 64'd0);
    chk("addi_rd_ad", {59'd0, out_rd_ad}, 64'd5);
    chk("addi_imm", {32'd0, out_imm}, 64'd7);
    chk("addi_ctrl", {54'd0, out_ctrl}, 64'h015);
    chk("addi_rd_wr", {63'd0, out_rd_wr}, 64'd1);

    // RAW on x5 (rs2=x5 present but unused)
    set_in(1, 10'h001, 32'h104, 32'd0, 5'd5, 1, 5'd5, 0, 5'd6, 1);
    chk("raw_stall", {63'd0, in_ready}, 64'd0);
    tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    set_wb(2'b10, 5'd0, 32'd0, 5'd5, 32'h1234);
`ifdef BYPASS_EN
    chk("byp_ready_N", {63'd0, in_ready}, 64'd1);
    tick();
    set_wb(2'b00, '0, '0, '0, '0);
`else
    chk("nobyp_ready_N", {63'd0, in_ready}, 64'd0);
    tick();
    set_wb(2'b00, '0, '0, '0, '0);
    chk("nobyp_ready_N1", {63'd0, in_ready}, 64'd1);
    tick();
`endif
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    chk("raw_valid", {63'd0, out_valid}, 64'd1);
    chk("raw_rs1", {32'd0, out_rs1}, 64'h1234);
    chk("raw_rs2_unused", {32'd0, out_rs2}, 64'd0);
    chk("raw_pc", {32'd0, out_pc}, 64'h104);

    // Back-pressure for 3 cycles
    out_ready = 1'b0;
    set_in(1, 10'h002, 32'h108, 32'd0, 5'd5, 1, 5'd0, 0, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_pc", {32'd0, out_pc}, 64'h104);
      tick();
    end
    chk("stall_pc_hold", {32'd0, out_pc}, 64'h104);
    out_ready = 1'b1;
    #1;
    chk("release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    chk("release_pc", {32'd0, out_pc}, 64'h108);
    chk("release_rs1", {32'd0, out_rs1}, 64'h1234);

    // Both ports write x3 in one cycle
    set_wb(2'b11, 5'd3, 32'hAA, 5'd3, 32'hBB);
    tick();
    set_wb(2'b00, '0, '0, '0, '0);
    set_in(1, 10'h003, 32'h10C, 32'd0, 5'd0, 0, 5'd3, 1, 5'd0, 0);
    tick();
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    chk("dual_wb_x3", {32'd0, out_rs2}, 64'hBB);
    chk("dual_wb_pc", {32'd0, out_pc}, 64'h10C);

    // Flush with busy x7 and a held packet; same-cycle wb to x9 still lands
    set_in(1, 10'h004, 32'h110, 32'd0, 5'd0, 0, 5'd0, 0, 5'd7, 1);
    tick();
    out_ready = 1'b0;
    set_in(1, 10'h005, 32'h114, 32'd0, 5'd7, 1, 5'd9, 1, 5'd0, 0);
    chk("x7_busy", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    set_wb(2'b01, 5'd9, 32'h55, 5'd0, 32'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    set_wb(2'b00, '0, '0, '0, '0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_sb_clear", {63'd0, in_ready}, 64'd1);
    tick();
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    out_ready = 1'b1;
    chk("post_flush_valid", {63'd0, out_valid}, 64'd1);
    chk("post_flush_pc", {32'd0, out_pc}, 64'h114);
    chk("post_flush_rs1", {32'd0, out_rs1}, 64'd0);
    chk("flush_wb_x9", {32'd0, out_rs2}, 64'h55);

    // rd=x0 write claim plus wb to x0
    set_in(1, 10'h006, 32'h118, 32'd0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    set_wb(2'b01, 5'd0, 32'hFF, 5'd0, 32'd0);
    tick();
    set_wb(2'b00, '0, '0, '0, '0);
    set_in(1, 10'h007, 32'h11C, 32'd0, 5'd0, 1, 5'd0, 1, 5'd0, 1);
    chk("x0_no_busy", {63'd0, in_ready}, 64'd1);
    tick();
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    chk("x0_rs1", {32'd0, out_rs1}, 64'd0);
    chk("x0_rs2", {32'd0, out_rs2}, 64'd0);

    // WAW on x8; unused rs1=x8 must not stall
    set_in(1, 10'h008, 32'h120, 32'd0, 5'd0, 0, 5'd0, 0, 5'd8, 1);
    tick();
    set_in(1, 10'h009, 32'h124, 32'd0, 5'd8, 0, 5'd0, 0, 5'd8, 1);
    chk("waw_stall", {63'd0, in_ready}, 64'd0);
    set_wb(2'b01, 5'd8, 32'h77, 5'd0, 32'd0);
`ifdef BYPASS_EN
    chk("waw_byp_ready", {63'd0, in_ready}, 64'd1);
    tick();
    set_wb(2'b00, '0, '0, '0, '0);
`else
    chk("waw_nobyp_ready", {63'd0, in_ready}, 64'd0);
    tick();
    set_wb(2'b00, '0, '0, '0, '0);
    chk("waw_ready_after", {63'd0, in_ready}, 64'd1);
    tick();
`endif
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    chk("waw_pc", {32'd0, out_pc}, 64'h124);
    chk("waw_rs1_unused", {32'd0, out_rs1}, 64'd0);
    // x8 re-claimed by the second writer
    set_in(1, 10'h00A, 32'h128, 32'd0, 5'd8, 1, 5'd0, 0, 5'd0, 0);
    chk("x8_reclaimed", {63'd0, in_ready}, 64'd0);
    set_in(0, '0, '0, '0, '0, 0, '0, 0, '0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
